pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter PC_RESET, default 64'h0000_0000_8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset; asynchronous, active-low.
REQ-004 redirect_valid  input  1  decode branch/jump taken this cycle.
REQ-005 redirect_pc  input  64  target from decode's branch-target adder.
REQ-006 ireq_valid  output  1  instruction fetch request.
REQ-007 ireq_addr  output  64  fetch address.
REQ-008 ireq_ready  input  1  memory accepts the request (handshake = ireq_valid && ireq_ready).
REQ-009 iresp_valid  input  1  one-cycle pulse; returned word valid.
REQ-010 iresp_data  input  32  returned instruction word.
REQ-011 out_valid  output  1  instruction held for decode.
REQ-012 out_pc  output  64  PC of the held instruction.
REQ-013 out_instr  output  32  held instruction.
REQ-014 out_ready  input  1  decode accepts (transfer = out_valid && out_ready).

Function
REQ-015 FSM states SHALL be REQ, WAIT and HOLD, with at most one fetch outstanding.
REQ-016 REQ: ireq_valid=1 and ireq_addr=pc; on handshake, go to WAIT.
REQ-017 ireq_addr SHALL stay stable while ireq_valid && !ireq_ready.
REQ-018 Redirect in REQ without handshake: pc SHALL load redirect_pc next cycle, and ireq_addr changes then.
REQ-019 Redirect in REQ on the handshake cycle: the issued request SHALL be marked stale, pend_pc=redirect_pc, and the FSM goes to WAIT.
REQ-020 WAIT: ireq_valid=0.
REQ-021 WAIT, iresp_valid with the request not stale: capture out_pc=pc and out_instr=iresp_data, pc<=pc+4, go to HOLD.
REQ-022 WAIT, iresp_valid with the request stale: discard data, pc<=pend_pc, clear stale, go to REQ.
REQ-023 Redirect in WAIT: set stale, pend_pc<=redirect_pc.
REQ-024 A later redirect SHALL overwrite pend_pc (last one wins).
REQ-025 Redirect and iresp_valid in the same WAIT cycle: the response SHALL be discarded and pc<=redirect_pc, then go to REQ.
REQ-026 HOLD: out_valid=1; on transfer, go to REQ (pc already incremented).
REQ-027 Redirect in HOLD: pc<=redirect_pc, go to REQ.
REQ-028 Redirect in HOLD on a transfer cycle: the transfer SHALL count and pc<=redirect_pc.
REQ-029 Redirect in HOLD without a transfer: the held instruction SHALL be dropped and out_valid=0 next cycle.
REQ-030 out_valid SHALL be 1 only in HOLD; out_pc and out_instr SHALL be stable while out_valid && !out_ready.
REQ-031 The pc+4 increment SHALL be 64-bit modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
REQ-032 redirect_pc SHALL be used as-is: no alignment masking and no exception generation.
REQ-033 Best-case throughput SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD), with zero-latency iresp: iresp_valid may assert the cycle after the handshake.
REQ-034 redirect_valid SHALL be ignored while resetn=0.

Reset
REQ-035 On resetn=0, immediately and independent of clk: state=REQ, pc=PC_RESET, stale=0, pend_pc=0, out_pc=0, out_instr=0.
REQ-036 After reset, the outputs SHALL be ireq_valid=1, ireq_addr=PC_RESET, out_valid=0.
REQ-037 Reset mid-transaction (WAIT or HOLD) SHALL abandon it; a late iresp_valid arriving in REQ SHALL be ignored.

Verification
REQ-038 Reset release, ireq_ready=1, iresp one cycle after the handshake, out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008, one out_valid every 3 cycles.
REQ-039 ireq_ready=0 for 4 cycles with a redirect to 0x80001000 in cycle 2 -> ireq_addr=0x80000000 then 0x80001000, no glitch while waiting; the first out_pc=0x80001000.
REQ-040 Redirect to 0x80002000 during WAIT, iresp_data=0xDEADBEEF -> the word is never presented; the next ireq_addr=0x80002000.
REQ-041 HOLD with out_ready=0 for 5 cycles -> out_pc and out_instr constant; then redirect to 0x80003000 with out_ready=0 -> out_valid=0 next cycle; the next fetch is at 0x80003000.
REQ-042 Redirect to 0xFFFFFFFFFFFFFFFC -> the following fetch is at 0x0.
REQ-043 Assert resetn=0 mid-WAIT, then return iresp_valid after release -> response ignored; ireq_addr=PC_RESET; out_valid stays 0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: one-outstanding instruction fetch with a
// skid-free hold slot for decode and branch/jump redirect handling.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   redirect_valid/_pc     taken branch/jump target from decode
//   ireq_valid/_addr/_ready  fetch request handshake to memory
//   iresp_valid/_data      one-cycle response pulse from memory
//   out_valid/_pc/_instr/_ready  held instruction toward decode
module pc_fetch_ctrl #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pc;
  logic [63:0] pend_pc;
  logic        stale;
  logic        hs;
  logic        xfer;

  assign hs   = ireq_valid && ireq_ready;
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        if (hs) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect or an earlier redirect makes the
        // returning word useless: refetch instead.
        if (iresp_valid) begin
          if (redirect_valid || stale) begin
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (xfer || redirect_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    ireq_valid = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      S_REQ:   ireq_valid = 1'b1;
      S_HOLD:  out_valid  = 1'b1;
      default: ;
    endcase
  end

  // pc only moves on a redirect or a state change, so the
  // request address is stable while the memory stalls.
  assign ireq_addr = pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc        <= PC_RESET;
      pend_pc   <= '0;
      stale     <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (redirect_valid) begin
            if (hs) begin
              // Request already left: let it return, then
              // throw the word away.
              stale   <= 1'b1;
              pend_pc <= redirect_pc;
            end else begin
              pc <= redirect_pc;
            end
          end
        end
        S_WAIT: begin
          if (iresp_valid) begin
            stale <= 1'b0;
            if (redirect_valid) begin
              pc <= redirect_pc;
            end else if (stale) begin
              pc <= pend_pc;
            end else begin
              out_pc    <= pc;
              out_instr <= iresp_data;
              pc        <= pc + 64'd4;
            end
          end else if (redirect_valid) begin
            stale   <= 1'b1;
            pend_pc <= redirect_pc;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed fetch, stall,
// redirect, hold, wrap and reset scenarios.
module tb_pc_fetch_ctrl;

  localparam logic [63:0] PCR = 64'h0000_0000_8000_0000;
  localparam logic [31:0] K   = 32'h1357_9BDF;

  logic        clk;
  logic        resetn;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   xfer_cyc[$];
  int   n_tests;
  int   n_fail;
  int   cyc;
  bit   auto_mem;

  logic [63:0] hpc;
  logic [31:0] hins;

  pc_fetch_ctrl #(.PC_RESET(PCR)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_ready    (ireq_ready),
    .iresp_valid   (iresp_valid),
    .iresp_data    (iresp_data),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_ready     (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ K;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: memory model samples the handshake away from the
  // edge and, in auto mode, answers in the very next cycle.
  task automatic step();
    logic        h;
    logic [63:0] a;
    @(negedge clk);
    h = ireq_valid && ireq_ready;
    a = ireq_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_mem) begin
      iresp_valid = h;
      iresp_data  = word(a);
    end
  endtask

  task automatic push(input logic [63:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = word(p);
    sb.push_back(e);
  endtask

  // Monitor: every decode transfer pops the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && out_valid && out_ready) begin
        xfer_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_xfer: got pc=%h instr=%h, expected none",
                   out_pc, out_instr);
        end else begin
          e = sb.pop_front();
          chk("xfer_pc", out_pc, e.pc);
          chk("xfer_instr", 64'(out_instr), 64'(e.instr));
        end
      end
    end
  end

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    cyc            = 0;
    auto_mem       = 1'b1;
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ireq_ready     = 1'b0;
    iresp_valid    = 1'b0;
    iresp_data     = '0;
    out_ready      = 1'b0;

    step();
    step();
    chk("rst_ireq_valid", 64'(ireq_valid), 64'd1);
    chk("rst_ireq_addr", ireq_addr, PCR);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    resetn = 1'b1;

    // Back-to-back fetch, one instruction every 3 cycles.
    ireq_ready = 1'b1;
    out_ready  = 1'b1;
    push(64'h8000_0000);
    push(64'h8000_0004);
    push(64'h8000_0008);
    for (int i = 0; i < 8; i++) step();
    chk("t1_hold_valid", 64'(out_valid), 64'd1);
    ireq_ready = 1'b0;
    step();
    chk("t1_xfers", 64'(xfer_cyc.size()), 64'd3);
    if (xfer_cyc.size() == 3) begin
      chk("t1_gap0", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd3);
      chk("t1_gap1", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd3);
    end
    chk("t1_next_valid", 64'(ireq_valid), 64'd1);

    // Stalled request with a redirect while waiting.
    chk("t2_addr_c1", ireq_addr, 64'h8000_000C);
    step();
    chk("t2_addr_c2", ireq_addr, 64'h8000_000C);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    step();
    redirect_valid = 1'b0;
    chk("t2_addr_c3", ireq_addr, 64'h8000_1000);
    step();
    chk("t2_addr_c4", ireq_addr, 64'h8000_1000);
    step();
    chk("t2_addr_c5", ireq_addr, 64'h8000_1000);
    ireq_ready = 1'b1;
    push(64'h8000_1000);
    step();
    ireq_ready = 1'b0;
    step();
    chk("t2_hold", 64'(out_valid), 64'd1);
    step();
    chk("t2_next_addr", ireq_addr, 64'h8000_1004);

    // Redirect during WAIT: returning word must be dropped.
    auto_mem   = 1'b0;
    ireq_ready = 1'b1;
    step();
    ireq_ready = 1'b0;
    chk("t3_wait_noreq", 64'(ireq_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    step();
    redirect_valid = 1'b0;
    iresp_valid    = 1'b1;
    iresp_data     = 32'hDEAD_BEEF;
    step();
    iresp_valid = 1'b0;
    chk("t3_req_valid", 64'(ireq_valid), 64'd1);
    chk("t3_req_addr", ireq_addr, 64'h8000_2000);
    chk("t3_no_out", 64'(out_valid), 64'd0);

    // Redirect on the handshake, another in WAIT: last wins.
    ireq_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2100;
    step();
    ireq_ready     = 1'b0;
    redirect_pc    = 64'h8000_2200;
    chk("t3b_wait", 64'(ireq_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    iresp_valid    = 1'b1;
    iresp_data     = 32'h1111_1111;
    step();
    iresp_valid = 1'b0;
    chk("t3b_addr", ireq_addr, 64'h8000_2200);
    chk("t3b_no_out", 64'(out_valid), 64'd0);

    // Redirect and response in the same WAIT cycle.
    ireq_ready = 1'b1;
    step();
    ireq_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2300;
    iresp_valid    = 1'b1;
    iresp_data     = 32'h2222_2222;
    step();
    redirect_valid = 1'b0;
    iresp_valid    = 1'b0;
    chk("t3c_addr", ireq_addr, 64'h8000_2300);
    chk("t3c_no_out", 64'(out_valid), 64'd0);
    step();
    chk("t3c_stable", ireq_addr, 64'h8000_2300);
    chk("t3c_no_out2", 64'(out_valid), 64'd0);

    // Hold under back-pressure, then a dropping redirect.
    auto_mem   = 1'b1;
    out_ready  = 1'b0;
    ireq_ready = 1'b1;
    step();
    ireq_ready = 1'b0;
    step();
    hpc  = 64'h8000_2300;
    hins = word(hpc);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_pc", out_pc, hpc);
      chk("t4_hold_instr", 64'(out_instr), 64'(hins));
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_3000;
    step();
    redirect_valid = 1'b0;
    chk("t4_dropped", 64'(out_valid), 64'd0);
    chk("t4_next_addr", ireq_addr, 64'h8000_3000);
    chk("t4_next_valid", 64'(ireq_valid), 64'd1);

    // Redirect on a transfer cycle: the transfer still counts.
    out_ready = 1'b1;
    push(64'h8000_3000);
    ireq_ready = 1'b1;
    step();
    ireq_ready = 1'b0;
    step();
    chk("t4b_hold", 64'(out_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("t4b_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // pc + 4 wraps to zero.
    push(64'hFFFF_FFFF_FFFF_FFFC);
    ireq_ready = 1'b1;
    step();
    ireq_ready = 1'b0;
    step();
    step();
    chk("t5_wrap_addr", ireq_addr, 64'd0);
    chk("t5_wrap_valid", 64'(ireq_valid), 64'd1);

    // Reset mid-WAIT, then a late response after release.
    auto_mem   = 1'b0;
    ireq_ready = 1'b1;
    step();
    ireq_ready = 1'b0;
    chk("t6_in_wait", 64'(ireq_valid), 64'd0);
    #2;
    resetn         = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1234_5678;
    #1;
    chk("t6_async_valid", 64'(ireq_valid), 64'd1);
    chk("t6_async_addr", ireq_addr, PCR);
    chk("t6_async_out", 64'(out_valid), 64'd0);
    chk("t6_async_opc", out_pc, 64'd0);
    chk("t6_async_oins", 64'(out_instr), 64'd0);
    step();
    chk("t6_rst_redirect", ireq_addr, PCR);
    resetn         = 1'b1;
    redirect_valid = 1'b0;
    iresp_valid    = 1'b1;
    iresp_data     = 32'h3333_3333;
    step();
    iresp_valid = 1'b0;
    chk("t6_late_out", 64'(out_valid), 64'd0);
    chk("t6_late_addr", ireq_addr, PCR);
    chk("t6_late_valid", 64'(ireq_valid), 64'd1);
    step();
    chk("t6_late_out2", 64'(out_valid), 64'd0);

    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
